// File: rtl/arb16_rr_pkg.sv
// arb16_pkg: shared sizes and FSM state type for the 16:1 round-robin arbiter (ARB16_TIMEOUT_EN adds the hold counter)
package arb16_pkg;
  localparam int N_REQ  = 16;
  localparam int IDX_W  = 4;
  localparam int HOLD_W = 8;
  typedef enum logic {IDLE, GRANT} state_e;
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: finds the first set request after ptr in circular order, optionally skipping one index
module rr_pick16
  import arb16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] w_cand;
  // scan distances 1..16 from ptr; ptr itself is checked last
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int d = 1; d <= N_REQ; d++) begin
      w_cand = ptr + IDX_W'(d);
      if (!found && req[w_cand] && !(excl_en && w_cand == excl_idx)) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end
endmodule

// File: rtl/arb16_rr.sv
// arb16_rr: registered 16:1 round-robin arbiter with zero-bubble handoff; ARB16_TIMEOUT_EN enables forced handoff after MAX_HOLD cycles
module arb16_rr
  import arb16_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] sel
);
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 1..255");
  end
  state_e           r_state, w_state_nx;
  logic [IDX_W-1:0] r_ptr, w_ptr_nx;
  logic [IDX_W-1:0] r_sel, w_sel_nx;
  logic [N_REQ-1:0] r_gnt, w_gnt_nx;
  logic             r_gnt_valid, w_valid_nx;
  logic             w_found, w_rel, w_new, w_hit;
  logic [IDX_W-1:0] w_idx;
  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign sel       = r_sel;
  // while granted, search from the owner and never pick it again in the handoff
  rr_pick16 u_pick (
    .req      (req),
    .ptr      (r_state == GRANT ? r_sel : r_ptr),
    .excl_en  (r_state == GRANT),
    .excl_idx (r_sel),
    .found    (w_found),
    .idx      (w_idx)
  );
`ifdef ARB16_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold;
  assign w_hit = r_hold >= HOLD_W'(MAX_HOLD - 1);
  // hold counter: cleared on every new grant, counts GRANT cycles, saturates at MAX_HOLD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_hold <= '0;
    else r_hold <= w_new ? '0 : (r_state == GRANT && r_hold < HOLD_W'(MAX_HOLD)) ? r_hold + 1'b1 : r_hold;
  end
`else
  assign w_hit = 1'b0;
`endif
  // next state: release on owner drop (or timeout with a waiter), then grant the next requester on the same edge
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_sel_nx   = r_sel;
    w_gnt_nx   = r_gnt;
    w_valid_nx = r_gnt_valid;
    w_new      = 1'b0;
    w_rel      = r_state == GRANT && (!req[r_sel] || (w_hit && w_found));
    if (w_rel) begin
      w_ptr_nx   = r_sel;
      w_state_nx = IDLE;
      w_gnt_nx   = '0;
      w_valid_nx = 1'b0;
    end
    if ((r_state == IDLE || w_rel) && w_found) begin
      w_new      = 1'b1;
      w_state_nx = GRANT;
      w_sel_nx   = w_idx;
      w_gnt_nx   = N_REQ'(1) << w_idx;
      w_valid_nx = 1'b1;
    end
  end
  // state and output registers; reset gives requester 0 first priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '1;
      r_sel       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_sel       <= w_sel_nx;
      r_gnt       <= w_gnt_nx;
      r_gnt_valid <= w_valid_nx;
    end
  end
endmodule

// File: tb/tb_arb16_rr.sv
// tb_arb16_rr: scoreboard bench for arb16_rr; expectations follow ARB16_TIMEOUT_EN when defined
module tb_arb16_rr;
  localparam int MH = 4;
`ifdef ARB16_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic [3:0]  sel;
  int total = 0;
  int bad = 0;
  logic [20:0] exp_q[$];
  bit       m_busy;
  logic [3:0] m_ptr, m_sel;
  int m_hold;
  int wait_c[16];
  int max_wait;

  arb16_rr #(.MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 1'b0; m_ptr = 4'hF; m_sel = 4'h0; m_hold = 0; max_wait = 0;
    foreach (wait_c[i]) wait_c[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [15:0] r);
    logic f;
    logic [3:0] idx, c, base;
    bit rel, newg;
    f = 1'b0; idx = '0; newg = 1'b0; rel = 1'b0;
    base = m_busy ? m_sel : m_ptr;
    for (int d = 1; d <= (m_busy ? 15 : 16); d++) begin
      c = base + 4'(d);
      if (!f && r[c]) begin f = 1'b1; idx = c; end
    end
    if (!m_busy) newg = f;
    else begin
      rel = !r[m_sel] || (TO && m_hold >= MH - 1 && f);
      if (rel) begin m_ptr = m_sel; m_busy = 1'b0; newg = f; end
      else if (m_hold < MH) m_hold++;
    end
    if (newg) begin m_busy = 1'b1; m_sel = idx; m_hold = 0; end
    for (int i = 0; i < 16; i++) begin
      if (!r[i] || (newg && idx == 4'(i))) wait_c[i] = 0;
      else if (newg) wait_c[i]++;
      if (wait_c[i] > max_wait) max_wait = wait_c[i];
    end
    exp_q.push_back({m_busy ? 16'(1) << m_sel : 16'h0, m_busy, m_sel});
  endtask

  task automatic step(input logic [15:0] r, input string nm);
    logic [20:0] e;
    @(negedge clk);
    req = r;
    model_edge(r);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (gnt !== e[20:5]) begin bad++; $display("FAIL %s gnt got=%h want=%h", nm, gnt, e[20:5]); end
    total++;
    if (gnt_valid !== e[4]) begin bad++; $display("FAIL %s gnt_valid got=%b want=%b", nm, gnt_valid, e[4]); end
    total++;
    if (sel !== e[3:0]) begin bad++; $display("FAIL %s sel got=%0d want=%0d", nm, sel, e[3:0]); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (gnt !== 16'h0) begin bad++; $display("FAIL reset gnt got=%h want=0000", gnt); end
    total++;
    if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset gnt_valid got=%b want=0", gnt_valid); end
    total++;
    if (sel !== 4'h0) begin bad++; $display("FAIL reset sel got=%0d want=0", sel); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(16'h0000, "idle");
  endtask

  task automatic test_single();
    do_reset();
    step(16'h0001, "single");
  endtask

  task automatic test_rotate();
    logic [15:0] one = 16'h0001;
    do_reset();
    step(16'hFFFF, "rot_first");
    for (int k = 0; k < 16; k++) step(16'hFFFF & ~(one << k), "rotate");
  endtask

  task automatic test_wrap();
    do_reset();
    step(16'h4000, "wrap_own14");
    step(16'h8001, "wrap_to15");
    step(16'h0001, "wrap_to0");
  endtask

  task automatic test_hold();
    do_reset();
    step(16'h0008, "hold_own3");
    repeat (6) step(16'h0028, "hold");
  endtask

  task automatic test_release();
    do_reset();
    step(16'h0104, "rel_own2");
    step(16'h0100, "rel_hand8");
    step(16'h0104, "rel_keep8");
    step(16'h0004, "rel_back2");
    step(16'h0000, "rel_idle");
  endtask

  task automatic test_nonowner();
    do_reset();
    step(16'h0020, "no_own5");
    repeat (6) step(16'h0020 | (16'($urandom) & 16'hFFDF), "nonowner");
  endtask

  task automatic test_async_reset();
    do_reset();
    step(16'h0080, "ar_own7");
    step(16'h0080, "ar_hold7");
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (gnt !== 16'h0) begin bad++; $display("FAIL async_reset gnt got=%h want=0000", gnt); end
    total++;
    if (gnt_valid !== 1'b0) begin bad++; $display("FAIL async_reset gnt_valid got=%b want=0", gnt_valid); end
    total++;
    if (sel !== 4'h0) begin bad++; $display("FAIL async_reset sel got=%0d want=0", sel); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(16'h0080, "ar_after");
  endtask

  task automatic test_random();
    logic [15:0] r;
    do_reset();
    repeat (10000) begin
      r = 16'($urandom) & 16'($urandom);
      step(r, "random");
      total++;
      if (!$onehot0(gnt) || (gnt_valid && gnt !== (16'(1) << sel))) begin
        bad++;
        $display("FAIL onehot gnt=%h sel=%0d valid=%b", gnt, sel, gnt_valid);
      end
    end
    total++;
    if (max_wait > 15) begin bad++; $display("FAIL starvation max_wait got=%0d want<=15", max_wait); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotate();
    test_wrap();
    test_hold();
    test_release();
    test_nonowner();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
